inst_fetch_ctrl: RTL and testbench

Instruction-fetch controller sitting between the byte-addressable instruction memory and the decode stage. It owns the program counter, arbitrates the single memory port between a byte-wide program loader and instruction fetch, and delivers fetched 32-bit instructions to decode over a valid/ready handshake. It also handles branch redirects, end-of-program halt, and fault reporting.

---
 rtl/inst_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, shares the memory port between the
// byte loader and fetch, and hands 32-bit instructions to decode over valid/ready.
module inst_fetch_ctrl #(
    parameter int          MEM_BYTES = 24,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load_req,
    input  logic        load_valid,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic        load_done,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FETCH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);
    localparam logic [31:0] LAST_PC     = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_code_q, inst_code_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fault_q, fault_d;

    logic        addr_ok_s;
    logic        slot_s;
    logic        redir_bad_s;

    assign addr_ok_s   = ({24'd0, load_addr} < MEM_BYTES_W);
    assign slot_s      = !inst_valid_q || inst_ready;
    assign redir_bad_s = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);

    // Next-state and datapath update for all four states
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_code_d  = inst_code_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (load_req) begin
                    state_d      = S_LOAD;
                    fault_d      = 1'b0;
                    inst_valid_d = 1'b0;
                end else if (start) begin
                    state_d      = S_FETCH;
                    pc_d         = RESET_PC;
                    fault_d      = 1'b0;
                    inst_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (load_valid && !addr_ok_s) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = fault_q;
                end
                if (load_done) begin
                    state_d = S_IDLE;
                    pc_d    = RESET_PC;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FETCH: begin
                // A redirect flushes the held instruction even if decode takes it now
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    if (redir_bad_s) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (slot_s) begin
                    if (pc_q <= LAST_PC) begin
                        inst_code_d  = mem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end else begin
                        inst_valid_d = 1'b0;
                        if (!inst_valid_q) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d      = S_IDLE;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_code_q  <= 32'd0;
            inst_pc_q    <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_code_q  <= inst_code_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_pc     = pc_q;
    assign mem_we     = (state_q == S_LOAD) && load_valid && addr_ok_s;
    assign mem_waddr  = load_addr;
    assign mem_wdata  = load_data;
    assign inst_valid = inst_valid_q;
    assign inst_code  = inst_code_q;
    assign inst_pc    = inst_pc_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_FETCH);
    assign done       = (state_q == S_HALT);
    assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: byte-memory model, expected-instruction
// queue filled by the stimulus and drained by an independent accept monitor.
module tb_inst_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_req = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [7:0]  load_data = 8'd0;
    logic        load_done = 1'b0;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        busy;
    logic        done;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:23];
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    logic [31:0] prog [0:5];

    inst_fetch_ctrl #(.MEM_BYTES(24), .RESET_PC(32'd0)) dut (
        .clock(clock), .reset(reset), .start(start), .load_req(load_req),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_done(load_done), .mem_pc(mem_pc), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_code(inst_code),
        .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < 32'd24) rd_byte = mem[a[4:0]];
        else            rd_byte = 8'h00;
    endfunction

    always_comb begin
        mem_rdata = {rd_byte(mem_pc + 32'd3), rd_byte(mem_pc + 32'd2),
                     rd_byte(mem_pc + 32'd1), rd_byte(mem_pc)};
    end

    always @(posedge clock) begin
        if (mem_we && (mem_waddr < 8'd24)) mem[mem_waddr[4:0]] <= mem_wdata;
    end

    // Accept monitor: a handshake not cancelled by a redirect must match the queue head
    always @(negedge clock) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL accept: got pc=0x%08h code=0x%08h, expected no instruction", inst_pc, inst_code);
            end else begin
                mon_e = exp_q.pop_front();
                if ({inst_code, inst_pc} !== mon_e) begin
                    miscompares++;
                    $display("FAIL accept: got pc=0x%08h code=0x%08h, expected pc=0x%08h code=0x%08h",
                             inst_pc, inst_code, mon_e[31:0], mon_e[63:32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic push_all();
        for (int k = 0; k < 6; k++) exp_q.push_back({prog[k], 32'(4 * k)});
    endtask

    task automatic wait_done(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (done) break;
            tick();
        end
        check("halt_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic start_fetch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 24; k++) mem[k] = 8'h00;
        prog[0] = 32'h00940333; prog[1] = 32'h412983b3; prog[2] = 32'h00a50533;
        prog[3] = 32'hfff00093; prog[4] = 32'h00208113; prog[5] = 32'h0000006f;

        tick(); tick();
        reset = 1'b0;
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_pc",    mem_pc, 32'd0);
        check("rst_code",  inst_code, 32'd0);
        check("rst_we",    {31'd0, mem_we}, 32'd0);

        // Load six words, least significant byte first
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("load_busy", {31'd0, busy}, 32'd1);
        for (int w = 0; w < 6; w++) begin
            for (int b = 0; b < 4; b++) begin
                load_valid = 1'b1;
                load_addr  = 8'(4 * w + b);
                load_data  = prog[w][8*b +: 8];
                tick();
            end
        end
        load_valid = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("load_idle", {31'd0, busy}, 32'd0);

        // Straight run, first valid two edges after start, then halt
        inst_ready = 1'b1;
        push_all();
        start_fetch();
        check("first_lat_valid", {31'd0, inst_valid}, 32'd0);
        check("fetch_busy", {31'd0, busy}, 32'd1);
        tick();
        check("first_valid", {31'd0, inst_valid}, 32'd1);
        check("first_pc", inst_pc, 32'd0);
        check("first_code", inst_code, 32'h00940333);
        for (int k = 1; k < 6; k++) begin
            tick();
            check("stream_pc", inst_pc, 32'(4 * k));
        end
        tick();
        check("end_valid", {31'd0, inst_valid}, 32'd0);
        check("end_notdone", {31'd0, done}, 32'd0);
        tick();
        check("end_done", {31'd0, done}, 32'd1);

        // Stall three cycles at pc 8
        push_all();
        start_fetch();
        tick(); tick(); tick();
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", inst_pc, 32'd8);
            check("stall_code", inst_code, 32'h00a50533);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        inst_ready = 1'b1;
        wait_done(20);
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Redirect to 16 while pc 4 is valid and ready
        exp_q.push_back({prog[0], 32'd0});
        exp_q.push_back({prog[4], 32'd16});
        exp_q.push_back({prog[5], 32'd20});
        start_fetch();
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'd16;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", {31'd0, inst_valid}, 32'd0);
        check("redir_pc", mem_pc, 32'd16);
        tick();
        check("redir_target", inst_pc, 32'd16);
        wait_done(10);
        check("redir_drained", 32'(exp_q.size()), 32'd0);

        // Misaligned redirect, then recovery by start
        start_fetch();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h00000006;
        tick();
        redirect_valid = 1'b0;
        check("misalign_fault", {31'd0, fault}, 32'd1);
        check("misalign_done", {31'd0, done}, 32'd1);
        check("misalign_valid", {31'd0, inst_valid}, 32'd0);
        push_all();
        start_fetch();
        check("restart_fault", {31'd0, fault}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(20);
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // Out-of-range redirect
        start_fetch();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'd24;
        tick();
        redirect_valid = 1'b0;
        check("range_fault", {31'd0, fault}, 32'd1);
        check("range_done", {31'd0, done}, 32'd1);
        check("range_valid", {31'd0, inst_valid}, 32'd0);

        // load_req beats start; bad address faults; start ignored in LOAD
        load_req = 1'b1;
        start = 1'b1;
        tick();
        load_req = 1'b0;
        check("ld_win_busy", {31'd0, busy}, 32'd1);
        check("ld_win_fault", {31'd0, fault}, 32'd0);
        check("ld_win_done", {31'd0, done}, 32'd0);
        load_valid = 1'b1;
        load_addr = 8'd30;
        load_data = 8'h55;
        #1;
        check("ld_bad_we", {31'd0, mem_we}, 32'd0);
        tick();
        load_valid = 1'b0;
        check("ld_bad_fault", {31'd0, fault}, 32'd1);
        tick();
        check("ld_ign_start", {31'd0, busy}, 32'd1);
        check("ld_ign_valid", {31'd0, inst_valid}, 32'd0);
        load_valid = 1'b1;
        load_addr = 8'd3;
        load_data = 8'h00;
        load_done = 1'b1;
        #1;
        check("ld_last_we", {31'd0, mem_we}, 32'd1);
        check("ld_last_addr", {24'd0, mem_waddr}, 32'd3);
        tick();
        load_valid = 1'b0;
        load_done = 1'b0;
        start = 1'b0;
        check("ld_exit_busy", {31'd0, busy}, 32'd0);
        check("ld_exit_done", {31'd0, done}, 32'd0);
        check("ld_exit_fault", {31'd0, fault}, 32'd1);

        // Reset while stalled mid-fetch
        inst_ready = 1'b0;
        start_fetch();
        tick(); tick(); tick();
        check("pre_rst_pc", inst_pc, 32'd0);
        check("pre_rst_mempc", mem_pc, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_pc", mem_pc, 32'd0);
        check("mid_rst_code", inst_code, 32'd0);
        check("mid_rst_fault", {31'd0, fault}, 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
